// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage core.
//
// Generates the PC write enable, the IF/ID hold/zero controls and the ID/EX,
// EX/MEM and MEM/WB stall/bubble controls. It resolves three hazard sources:
//   - load-use data hazards (ID needs a register a load in EX is producing)
//   - taken branches/jumps resolved in ID (the wrong-path fetch is squashed)
//   - multi-cycle data-memory accesses (the whole pipeline freezes)
// A registered FSM (IDLE/RUN/MEMWAIT/ERROR) sequences start-up and memory
// waits. A watchdog moves to a sticky ERROR state when a memory access waits
// MEM_TIMEOUT cycles.
//
// Optional build macro HAZARD_PERF_CNT_EN enables the stall_cycles and
// flush_count performance counters. When it is not defined both outputs are
// tied to zero and no counter registers exist.
//
// Ports:
//   clk, rst_n            clock (posedge), asynchronous active-low reset
//   start                 level; leaves IDLE when sampled high
//   id_rs1/id_rs2         ID-stage source register indices
//   id_use_rs1/id_use_rs2 ID instruction actually reads rs1/rs2
//   ex_memread, ex_rd     EX-stage load flag and destination index
//   branch_taken          ID-stage branch/jump resolved taken
//   mem_req, mem_ready    MEM-stage data memory request / completion
//   pc_write              PC load enable
//   IFstall, IFflush      hold / zero IF/ID register
//   idex_stall/idex_flush hold / bubble ID/EX register
//   exmem_stall           hold EX/MEM register
//   memwb_flush           bubble into MEM/WB
//   mem_err               sticky memory watchdog error
//   stall_cycles          cycles with pc_write=0 outside IDLE (optional)
//   flush_count           RUN cycles with IFflush=1 (optional)

module hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int MEM_TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_write,
  output logic             IFstall,
  output logic             IFflush,
  output logic             idex_stall,
  output logic             idex_flush,
  output logic             exmem_stall,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      flush_count
);

  // Watchdog counter is 8 bits wide, so the limit is taken modulo 256.
  localparam logic [7:0] TIMEOUT = MEM_TIMEOUT[7:0];

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_MEMWAIT = 2'd2,
    S_ERROR   = 2'd3
  } state_t;

  state_t     state_reg, state_next;
  logic [7:0] wait_cnt_reg, wait_cnt_next;
  logic       mem_err_reg, mem_err_next;

  logic load_use;
  logic mem_busy;

  // x0 is hard-wired zero, so a load targeting it never creates a hazard.
  assign load_use = ex_memread && (ex_rd != '0) &&
                    ((id_use_rs1 && (ex_rd == id_rs1)) ||
                     (id_use_rs2 && (ex_rd == id_rs2)));

  assign mem_busy = mem_req && !mem_ready;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= S_IDLE;
      wait_cnt_reg <= 8'd0;
      mem_err_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      mem_err_reg  <= mem_err_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    mem_err_next  = mem_err_reg;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_RUN;
      end
      S_RUN: begin
        if (mem_busy) begin
          // The first busy cycle already counts as one waiting cycle.
          wait_cnt_next = 8'd1;
          if (TIMEOUT == 8'd1) begin
            state_next   = S_ERROR;
            mem_err_next = 1'b1;
          end else begin
            state_next = S_MEMWAIT;
          end
        end
      end
      S_MEMWAIT: begin
        if (mem_ready) begin
          state_next    = S_RUN;
          wait_cnt_next = 8'd0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 8'd1;
          if (wait_cnt_reg + 8'd1 == TIMEOUT) begin
            state_next   = S_ERROR;
            mem_err_next = 1'b1;
          end
        end
      end
      S_ERROR: begin
        // Only reset leaves ERROR.
        state_next = S_ERROR;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  logic freeze;

  // A completing access (mem_ready in MEMWAIT) releases the freeze in the same
  // cycle, and the normal RUN priority decides that cycle's controls.
  assign freeze = (state_reg == S_ERROR) ||
                  ((state_reg == S_MEMWAIT) && !mem_ready) ||
                  ((state_reg == S_RUN) && mem_busy);

  always_comb begin
    pc_write    = 1'b0;
    IFstall     = 1'b0;
    IFflush     = 1'b0;
    idex_stall  = 1'b0;
    idex_flush  = 1'b0;
    exmem_stall = 1'b0;
    memwb_flush = 1'b0;
    if (state_reg == S_IDLE) begin
      IFflush    = 1'b1;
      idex_flush = 1'b1;
    end else if (freeze) begin
      IFstall     = 1'b1;
      idex_stall  = 1'b1;
      exmem_stall = 1'b1;
      memwb_flush = 1'b1;
    end else if (load_use) begin
      // Branch is ignored here: its operand depends on the pending load.
      IFstall    = 1'b1;
      idex_flush = 1'b1;
    end else if (branch_taken) begin
      pc_write = 1'b1;
      IFflush  = 1'b1;
    end else begin
      pc_write = 1'b1;
    end
  end

  assign mem_err = mem_err_reg;

  // ---------------------------------------------------------------------------
  // Optional performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles_reg;
  logic [31:0] flush_count_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_reg <= 32'd0;
      flush_count_reg  <= 32'd0;
    end else begin
      if ((state_reg != S_IDLE) && !pc_write)
        stall_cycles_reg <= stall_cycles_reg + 32'd1;
      if ((state_reg == S_RUN) && IFflush)
        flush_count_reg <= flush_count_reg + 32'd1;
    end
  end

  assign stall_cycles = stall_cycles_reg;
  assign flush_count  = flush_count_reg;
`else
  assign stall_cycles = 32'd0;
  assign flush_count  = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl (built with MEM_TIMEOUT=8).
// Each cycle the expected control vector is queued when stimulus is driven
// and popped/compared when the outputs are sampled mid-cycle.
// Control vector order: {pc_write, IFstall, IFflush, idex_stall, idex_flush,
//                        exmem_stall, memwb_flush, mem_err}

module tb_hazard_ctrl;

  localparam int REG_W = 5;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [7:0] V_IDLE   = 8'b0010_1000;
  localparam logic [7:0] V_NORM   = 8'b1000_0000;
  localparam logic [7:0] V_LDUSE  = 8'b0100_1000;
  localparam logic [7:0] V_BRANCH = 8'b1010_0000;
  localparam logic [7:0] V_FREEZE = 8'b0101_0110;
  localparam logic [7:0] V_ERROR  = 8'b0101_0111;

  logic             clk;
  logic             rst_n;
  logic             start;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2, ex_memread;
  logic             branch_taken, mem_req, mem_ready;
  logic             pc_write, IFstall, IFflush, idex_stall, idex_flush;
  logic             exmem_stall, memwb_flush, mem_err;
  logic [31:0]      stall_cycles, flush_count;
  logic [7:0]       ctrl;

  int errors = 0;
  int checks = 0;
  logic [31:0] stall_base;

  typedef struct {
    string      tag;
    logic [7:0] exp;
  } sb_entry_t;

  sb_entry_t sb_q[$];

  hazard_ctrl #(
    .REG_W      (REG_W),
    .MEM_TIMEOUT(8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_memread  (ex_memread),
    .ex_rd       (ex_rd),
    .branch_taken(branch_taken),
    .mem_req     (mem_req),
    .mem_ready   (mem_ready),
    .pc_write    (pc_write),
    .IFstall     (IFstall),
    .IFflush     (IFflush),
    .idex_stall  (idex_stall),
    .idex_flush  (idex_flush),
    .exmem_stall (exmem_stall),
    .memwb_flush (memwb_flush),
    .mem_err     (mem_err),
    .stall_cycles(stall_cycles),
    .flush_count (flush_count)
  );

  assign ctrl = {pc_write, IFstall, IFflush, idex_stall, idex_flush,
                 exmem_stall, memwb_flush, mem_err};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic st, input logic [REG_W-1:0] rs1,
                        input logic [REG_W-1:0] rs2, input logic u1,
                        input logic u2, input logic ld,
                        input logic [REG_W-1:0] rd, input logic br,
                        input logic req, input logic rdy);
    start        = st;
    id_rs1       = rs1;
    id_rs2       = rs2;
    id_use_rs1   = u1;
    id_use_rs2   = u2;
    ex_memread   = ld;
    ex_rd        = rd;
    branch_taken = br;
    mem_req      = req;
    mem_ready    = rdy;
  endtask

  // Queue the expectation for the stimulus just applied, sample mid-cycle,
  // compare, then advance to the next negedge.
  task automatic drive(input string tag, input logic [7:0] exp);
    sb_entry_t e;
    sb_q.push_back('{tag, exp});
    #2;
    e = sb_q.pop_front();
    $display("txn %-12s ctrl=%b exp=%b", e.tag, ctrl, e.exp);
    check(e.tag, {24'd0, ctrl}, {24'd0, e.exp});
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    drive("reset", V_IDLE);
    check("rst_stall", stall_cycles, 32'd0);
    check("rst_flush", flush_count, 32'd0);
    rst_n = 1'b1;

    // Three IDLE cycles, then start sampled, then running
    for (int i = 0; i < 3; i++) drive("idle", V_IDLE);
    start = 1'b1;
    drive("idle_start", V_IDLE);
    start = 1'b0;
    drive("run_first", V_NORM);

    // Load-use on rs2 with a simultaneous taken branch: branch ignored
    set_in(0, 3, 5, 0, 1, 1, 5, 1, 0, 0);
    drive("ldu_rs2_br", V_LDUSE);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("after_ldu", V_NORM);

    // Load-use on rs1
    set_in(0, 7, 1, 1, 0, 1, 7, 0, 0, 0);
    drive("ldu_rs1", V_LDUSE);
    // Load to x0 matching rs1: no hazard
    set_in(0, 0, 2, 1, 1, 1, 0, 0, 0, 0);
    drive("ld_x0", V_NORM);
    // Matching rs1 but instruction does not read rs1
    set_in(0, 7, 2, 0, 1, 1, 7, 0, 0, 0);
    drive("ld_nouse", V_NORM);
    // Matching index but not a load
    set_in(0, 9, 9, 1, 1, 0, 9, 0, 0, 0);
    drive("no_load", V_NORM);

    // Taken branch, no hazards
    set_in(0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
    drive("branch", V_BRANCH);
    check("flush_cnt1", flush_count, PERF ? 32'd1 : 32'd0);
    check("stall_cnt2", stall_cycles, PERF ? 32'd2 : 32'd0);

    // Memory access completing in the same cycle: no freeze
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 1);
    drive("mem_fast", V_NORM);

    // Four busy cycles, released on the fifth
    stall_base = stall_cycles;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 4; i++) drive("mem_wait", V_FREEZE);
    mem_ready = 1'b1;
    drive("mem_release", V_NORM);
    check("stall_mem", stall_cycles - stall_base, PERF ? 32'd4 : 32'd0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("post_mem", V_NORM);

    // Release together with a load-use hazard: RUN priority applies
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("mem2_wait", V_FREEZE);
    drive("mem2_wait", V_FREEZE);
    set_in(0, 4, 0, 1, 0, 1, 4, 1, 1, 1);
    drive("mem2_rel_ldu", V_LDUSE);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("post_mem2", V_NORM);

    // Watchdog: 8 waiting cycles with mem_ready low -> ERROR
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < 8; i++) drive("wd_wait", V_FREEZE);
    check("mem_err_set", {31'd0, mem_err}, 32'd1);
    mem_req = 1'b0;
    drive("err_hold", V_ERROR);
    set_in(1, 0, 0, 0, 0, 0, 0, 1, 1, 1);
    drive("err_sticky", V_ERROR);

    // Asynchronous reset clears the error without a clock edge
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", {24'd0, ctrl}, {24'd0, V_IDLE});
    @(negedge clk);
    rst_n = 1'b1;

    // Reset in the middle of a memory wait
    set_in(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("re_start", V_IDLE);
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
    drive("mw_enter", V_FREEZE);
    drive("mw_wait", V_FREEZE);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_memwait", {24'd0, ctrl}, {24'd0, V_IDLE});
    check("rst_mw_stall", stall_cycles, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive("idle_after", V_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
